// File: rtl/sobel_mem_seq.sv
// Fetches a 3x3 pixel window from memory, presents it, then writes one result back.
// Latency: 18 cycles from accepted start to window_valid with busy low, plus 1 cycle per busy-stalled cycle.
// Backpressure: busy stalls read/write issue and read capture; write is held until write_done.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_start, i_base_addr,
//   i_img_width                  window request; address and row stride latched on acceptance
//   i_busy, i_data_r_o,
//   i_write_done                 memory read/write interface status and read data
//   i_result, i_result_addr,
//   i_result_valid               Sobel magnitude and its destination, taken while the window is shown
//   o_start_read, o_addr_r_mc    one-cycle read request and its address
//   o_start_write, o_addr_w_mc,
//   o_data_w                     write request held until write_done, with address and data
//   o_window, o_window_valid     pixels P0..P8 (P0 in bits 7:0), valid while waiting for a result
//   o_done, o_seq_busy           completion pulse, high whenever not idle
module sobel_mem_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_base_addr,
    input  logic [7:0]  i_img_width,
    input  logic        i_busy,
    input  logic [7:0]  i_data_r_o,
    input  logic        i_write_done,
    input  logic [7:0]  i_result,
    input  logic [7:0]  i_result_addr,
    input  logic        i_result_valid,
    output logic        o_start_read,
    output logic [7:0]  o_addr_r_mc,
    output logic        o_start_write,
    output logic [7:0]  o_addr_w_mc,
    output logic [7:0]  o_data_w,
    output logic [71:0] o_window,
    output logic        o_window_valid,
    output logic        o_done,
    output logic        o_seq_busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_CAP  = 3'd2,
        S_WIN_RDY = 3'd3,
        S_WR_REQ  = 3'd4,
        S_WR_WAIT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_k;           // window byte index being fetched, 0..8
    logic [1:0]  r_row;
    logic [1:0]  r_col;
    logic [7:0]  r_row_base;    // address of the current row's first pixel
    logic [7:0]  r_img_width;
    logic [7:0]  r_addr_w;
    logic [7:0]  r_data_w;
    logic [71:0] r_window;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start)        w_next = S_RD_REQ;
            S_RD_REQ:  if (!i_busy)        w_next = S_RD_CAP;
            S_RD_CAP:  if (!i_busy)        w_next = (r_k == 4'd8) ? S_WIN_RDY : S_RD_REQ;
            S_WIN_RDY: if (i_result_valid) w_next = S_WR_REQ;
            S_WR_REQ:  if (!i_busy)        w_next = S_WR_WAIT;
            S_WR_WAIT: if (i_write_done)   w_next = S_DONE;
            S_DONE:                        w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    // Outputs; request strobes and their addresses are only non-zero while
    // the request is actually being made, so the two never overlap.
    always_comb begin
        o_start_read   = 1'b0;
        o_start_write  = 1'b0;
        o_window_valid = 1'b0;
        o_done         = 1'b0;
        o_seq_busy     = (r_state != S_IDLE);
        case (r_state)
            S_RD_REQ:  o_start_read   = !i_busy;
            S_WIN_RDY: o_window_valid = 1'b1;
            S_WR_REQ:  o_start_write  = !i_busy;
            S_WR_WAIT: o_start_write  = 1'b1;
            S_DONE:    o_done         = 1'b1;
            default:   ;
        endcase
        o_addr_r_mc = o_start_read  ? (r_row_base + {6'd0, r_col}) : 8'd0;
        o_addr_w_mc = o_start_write ? r_addr_w : 8'd0;
        o_data_w    = o_start_write ? r_data_w : 8'd0;
        o_window    = r_window;
    end

    // Datapath: fetch counters, window capture and write-back latches
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_k         <= 4'd0;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_row_base  <= 8'd0;
            r_img_width <= 8'd0;
            r_addr_w    <= 8'd0;
            r_data_w    <= 8'd0;
            r_window    <= 72'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_k         <= 4'd0;
                        r_row       <= 2'd0;
                        r_col       <= 2'd0;
                        r_row_base  <= i_base_addr;
                        r_img_width <= i_img_width;
                    end
                end
                S_RD_CAP: begin
                    if (!i_busy) begin
                        r_window[{r_k, 3'b000} +: 8] <= i_data_r_o;
                        // The ninth byte ends the fetch; counters are left as-is.
                        if (r_k != 4'd8) begin
                            r_k <= r_k + 4'd1;
                            if (r_col < 2'd2) begin
                                r_col <= r_col + 2'd1;
                            end else if (r_row < 2'd2) begin
                                r_col      <= 2'd0;
                                r_row      <= r_row + 2'd1;
                                r_row_base <= r_row_base + r_img_width;
                            end
                        end
                    end
                end
                S_WIN_RDY: begin
                    if (i_result_valid) begin
                        r_data_w <= i_result;
                        r_addr_w <= i_result_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_mem_seq.sv
`timescale 1ns/1ps
module tb_sobel_mem_seq;

    localparam int K_RD  = 0;
    localparam int K_WIN = 1;
    localparam int K_LAT = 2;
    localparam int K_WR  = 3;
    localparam int K_DN  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'd0;
    logic [7:0]  img_width = 8'd0;
    logic        busy = 1'b0;
    logic [7:0]  data_r_o = 8'd0;
    logic        write_done = 1'b0;
    logic [7:0]  result = 8'd0;
    logic [7:0]  result_addr = 8'd0;
    logic        result_valid = 1'b0;
    logic        start_read, start_write, window_valid, done, seq_busy;
    logic [7:0]  addr_r_mc, addr_w_mc, data_w;
    logic [71:0] window;

    sobel_mem_seq dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
        .i_img_width(img_width), .i_busy(busy), .i_data_r_o(data_r_o),
        .i_write_done(write_done), .i_result(result), .i_result_addr(result_addr),
        .i_result_valid(result_valid), .o_start_read(start_read), .o_addr_r_mc(addr_r_mc),
        .o_start_write(start_write), .o_addr_w_mc(addr_w_mc), .o_data_w(data_w),
        .o_window(window), .o_window_valid(window_valid), .o_done(done), .o_seq_busy(seq_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [71:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  nxt_data = 8'd0;
    int          wd_cnt = 0;

    typedef logic [7:0] addr_tab_t [9];
    addr_tab_t   t_basic = '{8'd10, 8'd11, 8'd12, 8'd30, 8'd31, 8'd32, 8'd50, 8'd51, 8'd52};
    addr_tab_t   t_wrap  = '{8'd250, 8'd251, 8'd252, 8'd254, 8'd255, 8'd0, 8'd2, 8'd3, 8'd4};
    addr_tab_t   t_stall = '{8'h40, 8'h41, 8'h42, 8'h50, 8'h51, 8'h52, 8'h60, 8'h61, 8'h62};
    addr_tab_t   t_rst   = '{8'h05, 8'h06, 8'h07, 8'h0D, 8'h0E, 8'h0F, 8'h15, 8'h16, 8'h17};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [71:0] v);
        exp_t e;
        e.kind = kind[2:0];
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [71:0] act, input string name,
                           output logic [71:0] expv);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            expv = '0;
            $display("FAIL %s actual=%0h expected=no event pending", name, act);
        end else begin
            e = sb.pop_front();
            expv = e.val;
            check(name, {5'd0, kind[2:0], act}, {5'd0, e.kind, e.val});
        end
    endtask

    // Cycle counter, advanced on every active edge
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: read data appears the cycle after the request;
    // write_done fires in the third cycle of a held write request.
    initial forever begin
        @(negedge clk);
        if (start_read) begin
            data_r_o = nxt_data;
            nxt_data = nxt_data + 8'd1;
        end
        if (start_write) begin
            wd_cnt++;
            write_done = (wd_cnt == 3);
        end else begin
            wd_cnt = 0;
            write_done = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event
    logic        m_prev_busy = 1'b0;
    logic        m_prev_wv = 1'b0;
    logic        m_prev_sw = 1'b0;
    int          m_t_start = 0;
    int          m_sw_cnt = 0;
    logic [71:0] m_ev;
    logic [71:0] m_wr_exp = '0;

    initial forever begin
        @(negedge clk);
        if (start_read) pop_cmp(K_RD, {64'd0, addr_r_mc}, "rd_addr", m_ev);
        if (busy) check("no_read_while_busy", {79'd0, start_read}, 80'd0);
        if (seq_busy && !m_prev_busy) m_t_start = cyc;
        if (window_valid && !m_prev_wv) begin
            pop_cmp(K_WIN, window, "window", m_ev);
            pop_cmp(K_LAT, 72'(cyc - m_t_start), "fetch_latency", m_ev);
        end
        if (start_write) begin
            check("rd_wr_exclusive", {79'd0, start_read}, 80'd0);
            if (!m_prev_sw) begin
                m_sw_cnt = 0;
                pop_cmp(K_WR, {56'd0, addr_w_mc, data_w}, "wr_addr_data", m_wr_exp);
            end else begin
                check("wr_held_stable", {64'd0, addr_w_mc, data_w}, {8'd0, m_wr_exp});
            end
            m_sw_cnt++;
        end
        if (done) pop_cmp(K_DN, 72'(m_sw_cnt), "wr_hold_cycles", m_ev);
        m_prev_busy = seq_busy;
        m_prev_wv   = window_valid;
        m_prev_sw   = start_write;
    end

    task automatic issue_fetch(input addr_tab_t addrs, input logic [7:0] b, input logic [7:0] w,
                               input int nreads, input logic [7:0] d0,
                               input logic [71:0] win, input int lat);
        @(negedge clk);
        base_addr = b;
        img_width = w;
        nxt_data  = d0;
        start     = 1'b1;
        for (int i = 0; i < nreads; i++) push(K_RD, {64'd0, addrs[i]});
        if (nreads == 9) begin
            push(K_WIN, win);
            push(K_LAT, 72'(lat));
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = ~b;     // latched copies must be unaffected
        img_width = ~w;
    endtask

    task automatic wait_window(input string name);
        int n = 0;
        while (!window_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!window_valid) begin
            checks++;
            errors++;
            $display("FAIL %s actual=timeout expected=window_valid", name);
        end
    endtask

    task automatic issue_write(input logic [7:0] res, input logic [7:0] ra, input int busy_cyc,
                               input string name);
        int n = 0;
        wait_window(name);
        @(negedge clk);
        result       = res;
        result_addr  = ra;
        result_valid = 1'b1;
        push(K_WR, {56'd0, ra, res});
        push(K_DN, 72'd3);
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        result       = ~res;
        result_addr  = ~ra;
        if (busy_cyc > 0) begin
            busy = 1'b1;
            repeat (busy_cyc) @(posedge clk);
            #1;
            busy = 1'b0;
        end
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done actual=timeout expected=done pulse", name);
        end
        // start during DONE must be ignored
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_idle_after_done"}, {78'd0, done, seq_busy}, 80'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        check("reset_outputs", {start_read, addr_r_mc, start_write, addr_w_mc, data_w,
                                window, window_valid, done, seq_busy}, 80'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic fetch and write-back
        issue_fetch(t_basic, 8'd10, 8'd20, 9, 8'h01, 72'h090807060504030201, 18);
        issue_write(8'hAB, 8'h77, 0, "basic_wr");

        // Address wrap; busy during write request
        issue_fetch(t_wrap, 8'd250, 8'd4, 9, 8'h21, 72'h292827262524232221, 18);
        issue_write(8'h5C, 8'hFF, 2, "wrap_wr");

        // Busy for 5 cycles during the 4th read request
        issue_fetch(t_stall, 8'h40, 8'h10, 9, 8'h11, 72'h191817161514131211, 23);
        n = 0;
        while (n < 3) begin
            @(negedge clk);
            if (start_read) n++;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        busy = 1'b0;
        issue_write(8'hC3, 8'h10, 0, "stall_wr");

        // Reset after the 5th read, then a fresh window
        issue_fetch(t_rst, 8'h05, 8'h08, 5, 8'h01, 72'd0, 0);
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            @(negedge clk);
            if (start_read) n++;
        end
        check("reads_before_reset", 80'(n), 80'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midfetch_reset_outputs", {start_read, addr_r_mc, start_write, addr_w_mc, data_w,
                                         window, window_valid, done, seq_busy}, 80'd0);
        repeat (2) @(negedge clk);
        check("reset_held_idle", {78'd0, done, seq_busy}, 80'd0);
        rst = 1'b0;
        issue_fetch(t_rst, 8'h05, 8'h08, 9, 8'h01, 72'h090807060504030201, 18);
        issue_write(8'h3E, 8'h01, 0, "post_rst_wr");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 80'(sb.size()), 80'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
